// File: rtl/stream_splitter_pkg.sv
// ============================================================================
// Module      : stream_splitter_pkg
// Description : Shared constants, slice-bound helpers and the branch
//               handshake bundle type for the stream splitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_splitter_pkg;

    // Default width of one output half; the input word is twice this.
    localparam int c_default_width = 8;

    // Slice bounds of the packed input word at the default width.
    localparam int c_lo_lsb = 0;
    localparam int c_lo_msb = c_default_width - 1;
    localparam int c_hi_lsb = c_default_width;
    localparam int c_hi_msb = 2 * c_default_width - 1;

    // One branch's valid/ready/data bundle at the default width.
    typedef struct packed {
        logic                       vld;
        logic                       rdy;
        logic [c_default_width-1:0] data;
    } branch_hs_t;

    // Slice bounds for an arbitrary half width.
    function automatic int lo_msb(input int w);
        return w - 1;
    endfunction

    function automatic int hi_lsb(input int w);
        return w;
    endfunction

    function automatic int hi_msb(input int w);
        return 2 * w - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_splitter_skid_buffer.sv
// ============================================================================
// Module      : stream_splitter_skid_buffer
// Description : 2-entry valid/ready buffer. Upstream ready is a registered
//               "not full", so downstream ready never reaches upstream
//               combinationally. One cycle latency, one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_splitter_skid_buffer
    import stream_splitter_pkg::*;
#(
    parameter int W = c_default_width
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_up_vld,
    output logic         o_up_rdy,
    input  logic [W-1:0] i_up_data,
    output logic         o_dn_vld,
    input  logic         i_dn_rdy,
    output logic [W-1:0] o_dn_data
);

    logic [W-1:0] r_mem_0;
    logic [W-1:0] r_mem_1;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_up_rdy;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    assign w_push      = i_up_vld & r_up_rdy;
    assign w_pop       = (r_count != 2'd0) & i_dn_rdy;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign o_up_rdy  = r_up_rdy;
    assign o_dn_vld  = (r_count != 2'd0);
    assign o_dn_data = r_rd_ptr ? r_mem_1 : r_mem_0;

    // Storage, pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_0  <= '0;
            r_mem_1  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_up_rdy <= 1'b1;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) r_mem_1 <= i_up_data;
                else          r_mem_0 <= i_up_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count  <= w_count_nxt;
            r_up_rdy <= (w_count_nxt != 2'd2);
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_splitter_with_flow_control.sv
// ============================================================================
// Module      : stream_splitter_with_flow_control
// Description : Eager fork of one 2*WIDTH valid/ready stream into two
//               WIDTH-bit streams (A = low half, B = high half). The input
//               word retires once both branches have taken it.
//               Build option STREAM_SPLITTER_OUT_REG_EN inserts a 2-entry
//               skid buffer on each branch (registered ready, 1 cycle
//               latency); without it the branches are purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_splitter_with_flow_control
    import stream_splitter_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [2*WIDTH-1:0] in_data,
    output logic               a_vld,
    input  logic               a_rdy,
    output logic [WIDTH-1:0]   a_data,
    output logic               b_vld,
    input  logic               b_rdy,
    output logic [WIDTH-1:0]   b_data
);

    logic             r_done_a;
    logic             r_done_b;

    logic             w_a_int_vld;
    logic             w_b_int_vld;
    logic             w_a_int_rdy;
    logic             w_b_int_rdy;
    logic             w_a_fire;
    logic             w_b_fire;
    logic [WIDTH-1:0] w_lo_data;
    logic [WIDTH-1:0] w_hi_data;

    assign w_lo_data = in_data[lo_msb(WIDTH):0];
    assign w_hi_data = in_data[hi_msb(WIDTH):hi_lsb(WIDTH)];

    // Valids are masked while reset is asserted so nothing is offered or
    // accepted during reset, even in the combinational build.
    assign w_a_int_vld = in_vld & ~r_done_a & rst_n;
    assign w_b_int_vld = in_vld & ~r_done_b & rst_n;

    assign w_a_fire = w_a_int_vld & w_a_int_rdy;
    assign w_b_fire = w_b_int_vld & w_b_int_rdy;

    assign in_rdy = (r_done_a | w_a_fire) & (r_done_b | w_b_fire);

    // Fork flags: remember which branch already took the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
        end else if (in_vld && in_rdy) begin
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
        end else begin
            if (w_a_fire) r_done_a <= 1'b1;
            if (w_b_fire) r_done_b <= 1'b1;
        end
    end

`ifdef STREAM_SPLITTER_OUT_REG_EN
    stream_splitter_skid_buffer #(
        .W (WIDTH)
    ) u_skid_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_up_vld  (w_a_int_vld),
        .o_up_rdy  (w_a_int_rdy),
        .i_up_data (w_lo_data),
        .o_dn_vld  (a_vld),
        .i_dn_rdy  (a_rdy),
        .o_dn_data (a_data)
    );

    stream_splitter_skid_buffer #(
        .W (WIDTH)
    ) u_skid_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_up_vld  (w_b_int_vld),
        .o_up_rdy  (w_b_int_rdy),
        .i_up_data (w_hi_data),
        .o_dn_vld  (b_vld),
        .i_dn_rdy  (b_rdy),
        .o_dn_data (b_data)
    );
`else
    assign a_vld       = w_a_int_vld;
    assign w_a_int_rdy = a_rdy;
    assign a_data      = w_lo_data;

    assign b_vld       = w_b_int_vld;
    assign w_b_int_rdy = b_rdy;
    assign b_data      = w_hi_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_splitter_with_flow_control.sv
// ============================================================================
// Module      : tb_stream_splitter_with_flow_control
// Description : Self-checking bench for stream_splitter_with_flow_control:
//               reset, cycle vector table, idle, mid-word reset and a
//               randomized-ready stream checked against per-branch
//               in-order word lists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_splitter_with_flow_control;
    import stream_splitter_pkg::*;

    localparam int W = c_default_width;

    logic           clk;
    logic           rst_n;
    logic           in_vld;
    logic           in_rdy;
    logic [2*W-1:0] in_data;
    logic           a_vld;
    logic           a_rdy;
    logic [W-1:0]   a_data;
    logic           b_vld;
    logic           b_rdy;
    logic [W-1:0]   b_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic           in_vld;
        logic [2*W-1:0] in_data;
        branch_hs_t     a;          // rdy = drive, vld/data = expected
        branch_hs_t     b;
        logic           exp_in_rdy;
    } vec_t;

    stream_splitter_with_flow_control #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .a_vld   (a_vld),
        .a_rdy   (a_rdy),
        .a_data  (a_data),
        .b_vld   (b_vld),
        .b_rdy   (b_rdy),
        .b_data  (b_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2*W-1:0] d,
                                input logic ar, input logic br,
                                input logic eav, input logic ebv, input logic eir);
        vec_t r;
        r.in_vld     = v;
        r.in_data    = d;
        r.a.rdy      = ar;
        r.a.vld      = eav;
        r.a.data     = d[c_lo_msb:c_lo_lsb];
        r.b.rdy      = br;
        r.b.vld      = ebv;
        r.b.data     = d[c_hi_msb:c_hi_lsb];
        r.exp_in_rdy = eir;
        return r;
    endfunction

    // Stream the given words with random branch readiness; each branch must
    // see exactly the list of halves, in order, once each.
    task automatic run_stream(input logic [2*W-1:0] words[$], input string tag);
        int n   = words.size();
        int p   = 0;
        int ai  = 0;
        int bi  = 0;
        int cyc = 0;
        logic [2*W-1:0] w;
        while ((p < n || ai < n || bi < n) && cyc < 20000) begin
            @(negedge clk);
            in_vld  = (p < n);
            in_data = (p < n) ? words[p] : '0;
            a_rdy   = 1'($urandom_range(0, 1));
            b_rdy   = 1'($urandom_range(0, 1));
            #2;
            if (a_vld && a_rdy) begin
                if (ai < n) begin
                    w = words[ai];
                    check($sformatf("%s a_data[%0d]", tag, ai), 32'(a_data), 32'(w[c_lo_msb:c_lo_lsb]));
                end else begin
                    check($sformatf("%s a_extra", tag), ai, n - 1);
                end
                ai++;
            end
            if (b_vld && b_rdy) begin
                if (bi < n) begin
                    w = words[bi];
                    check($sformatf("%s b_data[%0d]", tag, bi), 32'(b_data), 32'(w[c_hi_msb:c_hi_lsb]));
                end else begin
                    check($sformatf("%s b_extra", tag), bi, n - 1);
                end
                bi++;
            end
            // A branch may only be working on the word currently offered.
            check($sformatf("%s a_ahead", tag), 32'(ai <= p + 1), 32'd1);
            check($sformatf("%s b_ahead", tag), 32'(bi <= p + 1), 32'd1);
            if (in_vld && in_rdy) p++;
            cyc++;
        end
        check($sformatf("%s timeout", tag), 32'(cyc < 20000), 32'd1);
        check($sformatf("%s words_retired", tag), p, n);
        check($sformatf("%s a_count", tag), ai, n);
        check($sformatf("%s b_count", tag), bi, n);
        @(negedge clk);
        in_vld = 1'b0;
        a_rdy  = 1'b1;
        b_rdy  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2;
            check($sformatf("%s drain_a_vld", tag), 32'(a_vld), 32'd0);
            check($sformatf("%s drain_b_vld", tag), 32'(b_vld), 32'd0);
        end
    endtask

    initial begin
        logic [2*W-1:0] words[$];
`ifndef STREAM_SPLITTER_OUT_REG_EN
        vec_t tbl[10];
        tbl[0] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // simultaneous
        tbl[2] = mk(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // A fires
        tbl[3] = mk(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // no dup on A
        tbl[4] = mk(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); // B fires, retire
        tbl[6] = mk(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); // B first
        tbl[7] = mk(1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // idle, flags held
        tbl[8] = mk(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); // A finishes
        tbl[9] = mk(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // Reset with a word offered: nothing may be offered or accepted.
        rst_n   = 1'b0;
        in_vld  = 1'b1;
        in_data = 16'hBEEF;
        a_rdy   = 1'b1;
        b_rdy   = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst a_vld", 32'(a_vld), 32'd0);
        check("rst b_vld", 32'(b_vld), 32'd0);
        check("rst in_rdy", 32'(in_rdy), 32'd0);
        @(negedge clk);
        in_vld = 1'b0;
        rst_n  = 1'b1;

`ifndef STREAM_SPLITTER_OUT_REG_EN
        // Cycle-by-cycle vectors.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_vld  = tbl[i].in_vld;
            in_data = tbl[i].in_data;
            a_rdy   = tbl[i].a.rdy;
            b_rdy   = tbl[i].b.rdy;
            #2;
            check($sformatf("vec%0d in_rdy", i), 32'(in_rdy), 32'(tbl[i].exp_in_rdy));
            check($sformatf("vec%0d a_vld", i), 32'(a_vld), 32'(tbl[i].a.vld));
            check($sformatf("vec%0d b_vld", i), 32'(b_vld), 32'(tbl[i].b.vld));
            if (tbl[i].a.vld) check($sformatf("vec%0d a_data", i), 32'(a_data), 32'(tbl[i].a.data));
            if (tbl[i].b.vld) check($sformatf("vec%0d b_data", i), 32'(b_data), 32'(tbl[i].b.data));
        end
        // Drop the pending vec9 word cleanly (both fire together).
        @(negedge clk);
        a_rdy = 1'b1;
        b_rdy = 1'b1;
`endif

        // Idle: no valid on either branch.
        @(negedge clk);
        in_vld = 1'b0;
        a_rdy  = 1'b1;
        b_rdy  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #2;
            check("idle a_vld", 32'(a_vld), 32'd0);
            check("idle b_vld", 32'(b_vld), 32'd0);
        end

`ifndef STREAM_SPLITTER_OUT_REG_EN
        // Mid-word reset: A delivered, B stalled, then reset.
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = 16'hBEEF;
        a_rdy   = 1'b1;
        b_rdy   = 1'b0;
        #2;
        check("mwr a_fire", 32'(a_vld), 32'd1);
        check("mwr in_rdy0", 32'(in_rdy), 32'd0);
        @(negedge clk);
        #2;
        check("mwr a_done", 32'(a_vld), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mwr rst a_vld", 32'(a_vld), 32'd0);
        check("mwr rst b_vld", 32'(b_vld), 32'd0);
        check("mwr rst in_rdy", 32'(in_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_rdy = 1'b1;
        #2;
        check("mwr reoffer a_vld", 32'(a_vld), 32'd1);
        check("mwr reoffer b_vld", 32'(b_vld), 32'd1);
        check("mwr reoffer a_data", 32'(a_data), 32'h00EF);
        check("mwr reoffer b_data", 32'(b_data), 32'h00BE);
        check("mwr reoffer in_rdy", 32'(in_rdy), 32'd1);
        @(negedge clk);
        in_vld = 1'b0;
`endif

        // Back-to-back stream of 256 words, then random payloads.
        for (int i = 0; i < 256; i++) words.push_back(16'(i));
        run_stream(words, "seq");
        words.delete();
        for (int i = 0; i < 64; i++) words.push_back(16'($urandom));
        run_stream(words, "rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
